// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_stage
// Description : Operand-fetch stage. Holds the architectural register file,
//               reads both sources (with same-cycle write-back bypass),
//               detects a load-use style hazard against the instruction in
//               the output register and presents registered operands to a
//               registered ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    // issue slot
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [2:0]      in_ctrl,
    input  logic            in_we,

    // discard the instruction that would enter the output register
    input  logic            flush,

    // write-back from the ALU result register
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,

    // registered operands to the ALU
    output logic            out_valid,
    output logic [2:0]      out_ctrl,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd_addr,
    output logic            out_we
);

    localparam logic [4:0] c_X0 = 5'd0;

    // ------------------------------------------------------------------------
    // Register file storage. Entry 0 is cleared on reset and never written,
    // so it reads as zero without a dedicated mux leg on the storage side.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_wb_write;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_hazard;
    logic            w_accept;

    logic            r_out_valid;
    logic [2:0]      r_out_ctrl;
    logic [XLEN-1:0] r_out_rs1;
    logic [XLEN-1:0] r_out_rs2;
    logic [4:0]      r_out_rd_addr;
    logic            r_out_we;

    // A write-back to x0, or to an index beyond the implemented file, is dropped.
    assign w_wb_write = wb_en && (wb_addr != c_X0) && (int'(wb_addr) < NREGS);

    // Register file write port; flush has no influence here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Source reads: x0 is zero, a same-cycle write-back to the source wins
    // over the stored value, otherwise the stored value.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (in_rs1_addr == c_X0 || int'(in_rs1_addr) >= NREGS) begin
            w_rs1_val = '0;
        end else if (w_wb_write && (wb_addr == in_rs1_addr)) begin
            w_rs1_val = wb_data;
        end else begin
            w_rs1_val = r_regs[in_rs1_addr];
        end
        if (in_rs2_addr == c_X0 || int'(in_rs2_addr) >= NREGS) begin
            w_rs2_val = '0;
        end else if (w_wb_write && (wb_addr == in_rs2_addr)) begin
            w_rs2_val = wb_data;
        end else begin
            w_rs2_val = r_regs[in_rs2_addr];
        end
    end

    // The instruction in the output register has not produced its result yet
    // (it is still in the ALU next cycle), so a consumer of its rd must wait
    // one cycle and then picks the value up through the write-back bypass.
    assign w_hazard = r_out_valid && r_out_we && (r_out_rd_addr != c_X0) &&
                      ((r_out_rd_addr == in_rs1_addr) ||
                       (r_out_rd_addr == in_rs2_addr));

    assign in_ready = !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    // Output control: valid/we follow acceptance every cycle so a stall,
    // flush or empty slot becomes a bubble that cannot write back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            r_out_we    <= w_accept && in_we;
        end
    end

    // Output payload: only loaded on acceptance; stale contents while the
    // slot is invalid are harmless because valid/we are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_ctrl    <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_rd_addr <= '0;
        end else if (w_accept) begin
            r_out_ctrl    <= in_ctrl;
            r_out_rs1     <= w_rs1_val;
            r_out_rs2     <= w_rs2_val;
            r_out_rd_addr <= in_rd_addr;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_ctrl    = r_out_ctrl;
    assign out_rs1     = r_out_rs1;
    assign out_rs2     = r_out_rs2;
    assign out_rd_addr = r_out_rd_addr;
    assign out_we      = r_out_we;

endmodule
`default_nettype wire

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and register width.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning architectural register count, addressed by 5-bit indices.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  issue slot holds an instruction.
REQ-006 The block SHALL have port in_ready  output  1  stage accepts the issue slot this cycle.
REQ-007 The block SHALL have ports in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  source and destination indices.
REQ-008 The block SHALL have port in_ctrl  input  3  ALU operation code, passed through unmodified.
REQ-009 The block SHALL have port in_we  input  1  instruction writes rd.
REQ-010 The block SHALL have port flush  input  1  discard the instruction held in the output register.
REQ-011 The block SHALL have ports wb_en  input  1, wb_addr  input  5, and wb_data  input  XLEN  write-back from the ALU result.
REQ-012 The block SHALL have ports out_valid  output  1, out_ctrl  output  3, out_rs1  output  XLEN, out_rs2  output  XLEN, out_rd_addr  output  5, and out_we  output  1  registered operands to the ALU.

Function
REQ-013 The block SHALL hold an NREGS x XLEN register file; x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-014 The block SHALL write wb_data into register wb_addr at the rising edge when wb_en=1 and wb_addr!=0.
REQ-015 The block SHALL bypass reads: if wb_en=1, wb_addr!=0 and wb_addr equals a source address in the same cycle, that source SHALL read wb_data, not the stored value.
REQ-016 The block SHALL compute the hazard as out_valid & out_we & (out_rd_addr!=0) & (out_rd_addr==in_rs1_addr | out_rd_addr==in_rs2_addr).
REQ-017 The block SHALL drive in_ready = !hazard & !flush, combinationally.
REQ-018 On in_valid & in_ready, the block SHALL at the next edge set out_valid=1, latch both source values (after bypass), and latch in_ctrl, in_rd_addr and in_we into the out_* registers; latency is 1 cycle.
REQ-019 When in_valid=0, hazard=1 or flush=1, the block SHALL set out_valid=0 at the next edge, inserting a bubble, with out_we also cleared.
REQ-020 The block SHALL hold a stalled issue slot: the source keeps in_* stable while in_ready=0, and the instruction is accepted the cycle after the hazard clears.
REQ-021 The block SHALL not latch data into out_* registers when no instruction is accepted, except that out_valid and out_we clear; stale operand values are permitted.
REQ-022 The system SHALL present write-back of an instruction exactly 2 cycles after it is accepted, i.e. one cycle after its out_valid, matching the registered ALU; the bypass of REQ-015 covers the dependent instruction read in that cycle.
REQ-023 The block SHALL give flush priority over acceptance, and flush SHALL NOT block register-file writes.
REQ-024 A dependent back-to-back pair SHALL incur exactly one bubble cycle; a pair with a distance of 2 or more SHALL incur none.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously clear all registers to 0 and drive out_valid=0, out_we=0, out_ctrl=0, out_rs1=0, out_rs2=0 and out_rd_addr=0.
REQ-026 In the first cycle after reset release, the block SHALL drive in_ready=1, since there is no pending hazard.
REQ-027 A reset asserted mid-stall SHALL drop the pending instruction and leave no partial write.

Verification
REQ-028 The bench SHALL cover the write-then-read case: wb x5=0x1234, then issue rs1=x5 and rs2=x0 -> out_rs1=0x1234 and out_rs2=0 one cycle later.
REQ-029 The bench SHALL cover the x0 write case: wb_en with wb_addr=0 and data 0xFFFFFFFF, then read x0 -> 0.
REQ-030 The bench SHALL cover the dependent pair: issue add rd=x3, then next cycle issue rs1=x3 -> in_ready=0 for one cycle, one out_valid bubble, and the second instruction receives the bypassed x3 value.
REQ-031 The bench SHALL cover the same-cycle bypass: wb x7=0xA5A5A5A5 in the same cycle as issue rs2=x7 with a stored value of 0 -> out_rs2=0xA5A5A5A5.
REQ-032 The bench SHALL cover flush: flush=1 while in_valid=1 -> in_ready=0, out_valid=0 next cycle, and a concurrent wb still writes.
REQ-033 The bench SHALL cover reset mid-stream: rst_n low during a stall -> all out_* go to 0 immediately and registers read 0 after release.
